// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM state encoding and default sizes.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [2*WIDTH-1:0] sum_s;
    logic [WIDTH-1:0]   mplier_r;
    logic [SHW:0]       cnt_r;
    logic               busy_r;

    // Accumulator value after the current iteration; exposed so the final product is usable on the last edge
    always_comb begin
        sum_s = acc_r;
        if (mplier_r[0]) begin
            sum_s = acc_r + mcand_r;
        end else begin
            sum_s = acc_r;
        end
    end

    // Iteration state: multiplicand shifts left, multiplier shifts right, counter tracks the bit index
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {(SHW+1){1'b0}};
            busy_r   <= 1'b0;
        end else if (load) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= {(SHW+1){1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= sum_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (cnt_r == CNT_LAST) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + {{SHW{1'b0}}, 1'b1};
            end
        end
    end

    assign busy       = busy_r;
    assign last       = busy_r && (cnt_r == CNT_LAST);
    assign prod_lo    = sum_s[WIDTH-1:0];
    assign prod_hi_nz = |sum_s[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: captures T1/T2 operands on start, runs one op, and holds result/flags for write-back.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    state_t           state_r, state_nx;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             accept_s;
    logic             mul_last_s, mul_busy_s, mul_hi_nz_s;
    logic [WIDTH-1:0] mul_lo_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH:0]   add_s, sub_s, sll_s, srl_s, sra_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_v_s, alu_ill_s;
    logic [WIDTH-1:0] result_r;
    logic             busy_r, done_r, z_r, n_r, c_r, v_r, ill_r;

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

    alu_mul_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .load       (accept_s && (op == ALU_MUL)),
        .a          (opnd_a),
        .b          (opnd_b),
        .busy       (mul_busy_s),
        .last       (mul_last_s),
        .prod_lo    (mul_lo_s),
        .prod_hi_nz (mul_hi_nz_s)
    );

    // Next-state logic; DONE accepts a new op exactly like IDLE so back-to-back ops have no gap
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nx = (op == ALU_MUL) ? MUL : EXEC;
                end else begin
                    state_nx = IDLE;
                end
            end
            EXEC:    state_nx = DONE;
            MUL: begin
                if (mul_last_s) begin
                    state_nx = DONE;
                end else begin
                    state_nx = MUL;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle datapath; extended shifts put the last shifted-out bit in the extra position
    always_comb begin
        sh_s      = b_r[SHW-1:0];
        add_s     = {1'b0, a_r} + {1'b0, b_r};
        sub_s     = {1'b0, a_r} - {1'b0, b_r};
        sll_s     = {1'b0, a_r} << sh_s;
        srl_s     = {a_r, 1'b0} >> sh_s;
        sra_s     = $signed({a_r, 1'b0}) >>> sh_s;
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_ill_s = 1'b0;
        case (op_r)
            ALU_ADD: begin
                alu_res_s = add_s[WIDTH-1:0];
                alu_c_s   = add_s[WIDTH];
                alu_v_s   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res_s = sub_s[WIDTH-1:0];
                alu_c_s   = sub_s[WIDTH];
                alu_v_s   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            ALU_AND: alu_res_s = a_r & b_r;
            ALU_OR:  alu_res_s = a_r | b_r;
            ALU_XOR: alu_res_s = a_r ^ b_r;
            ALU_SLL: begin
                alu_res_s = sll_s[WIDTH-1:0];
                alu_c_s   = sll_s[WIDTH];
            end
            ALU_SRL: begin
                alu_res_s = srl_s[WIDTH:1];
                alu_c_s   = srl_s[0];
            end
            ALU_SRA: begin
                alu_res_s = sra_s[WIDTH:1];
                alu_c_s   = sra_s[0];
            end
            ALU_MUL: alu_res_s = {WIDTH{1'b0}};
            default: alu_ill_s = 1'b1;
        endcase
    end

    // State, status outputs and operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            op_r    <= 4'd0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nx;
            busy_r  <= (state_nx == EXEC) || (state_nx == MUL);
            done_r  <= (state_nx == DONE);
            if (accept_s) begin
                op_r <= op;
                a_r  <= opnd_a;
                b_r  <= opnd_b;
            end
        end
    end

    // Result and flags load only on the edge entering DONE, then hold for write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {WIDTH{1'b0}};
            z_r      <= 1'b0;
            n_r      <= 1'b0;
            c_r      <= 1'b0;
            v_r      <= 1'b0;
            ill_r    <= 1'b0;
        end else if (state_r == EXEC) begin
            result_r <= alu_res_s;
            z_r      <= (alu_res_s == {WIDTH{1'b0}});
            n_r      <= alu_res_s[WIDTH-1];
            c_r      <= alu_c_s;
            v_r      <= alu_v_s;
            ill_r    <= alu_ill_s;
        end else if ((state_r == MUL) && mul_last_s) begin
            result_r <= mul_lo_s;
            z_r      <= (mul_lo_s == {WIDTH{1'b0}});
            n_r      <= mul_lo_s[WIDTH-1];
            c_r      <= mul_hi_nz_s;
            v_r      <= 1'b0;
            ill_r    <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign flag_z  = z_r;
    assign flag_n  = n_r;
    assign flag_c  = c_r;
    assign flag_v  = v_r;
    assign illegal = ill_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Table-driven scoreboard bench for alu_exec_unit plus hand-written multi-cycle corner sequences.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   op;
    logic [W-1:0] opnd_a, opnd_b;
    logic         busy, done, flag_z, flag_n, flag_c, flag_v, illegal;
    logic [W-1:0] result;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        ill;
    } vec_t;

    vec_t vecs [0:19];
    vec_t q_exp [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_seen;

    alu_exec_unit #(.WIDTH(W), .SHW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .busy(busy), .done(done), .result(result), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse pops and checks the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                vec_t e;
                e = q_exp.pop_front();
                chk("result",  result, e.res);
                chk("flag_z",  {31'd0, flag_z},  {31'd0, e.z});
                chk("flag_n",  {31'd0, flag_n},  {31'd0, e.n});
                chk("flag_c",  {31'd0, flag_c},  {31'd0, e.c});
                chk("flag_v",  {31'd0, flag_v},  {31'd0, e.v});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic issue(input vec_t v);
        op = v.op; opnd_a = v.a; opnd_b = v.b; start = 1'b1;
        q_exp.push_back(v);
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); opnd_a = $urandom; opnd_b = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input int exp_busy, input string name);
        int  lat = 0;
        int  bsy = 0;
        bit  seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, bsy, exp_busy);
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{ALU_OR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{ALU_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ALU_SLL, 32'h80000001, 32'h00000021, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{ALU_SRL, 32'h80000001, 32'h00000001, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{ALU_SRA, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{ALU_SRL, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{ALU_SRA, 32'h70000000, 32'h00000004, 32'h07000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{ALU_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'hC,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{ALU_ADD, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{ALU_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{ALU_MUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{ALU_MUL, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{4'hF,    32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{ALU_MUL, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = 4'd0; opnd_a = 32'd0; opnd_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, busy},    32'd0);
        chk("reset_done",   {31'd0, done},    32'd0);
        chk("reset_result", result,           32'd0);
        chk("reset_flags",  {27'd0, flag_z, flag_n, flag_c, flag_v, illegal}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i]);
            if (vecs[i].op == ALU_MUL) wait_done(33, 32, $sformatf("vec%0d", i));
            else                       wait_done(2, 1, $sformatf("vec%0d", i));
        end

        // MUL with an ADD start pulse while busy: the pulse must be ignored
        issue(vecs[15]);
        repeat (4) @(posedge clk);
        #1;
        op = ALU_ADD; opnd_a = 32'd1; opnd_b = 32'd1; start = 1'b1;
        chk("ignored_start_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(28, 27, "mul_ignore_start");

        // Back-to-back with start held high: ADD then XOR, no idle gap
        op = ALU_ADD; opnd_a = 32'd3; opnd_b = 32'd4; start = 1'b1;
        q_exp.push_back(vecs[14]);
        @(posedge clk); #1;
        op = ALU_XOR; opnd_a = 32'hF; opnd_b = 32'hF;
        q_exp.push_back('{ALU_XOR, 32'hF, 32'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_first_done_popped", q_exp.size(), 32'd1);
        chk("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
        wait_done(2, 1, "b2b_second");

        // Reset in the middle of a MUL: op abandoned, no done pulse afterwards
        issue(vecs[19]);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy",   {31'd0, busy},   32'd0);
        chk("midrst_done",   {31'd0, done},   32'd0);
        chk("midrst_result", result,          32'd0);
        chk("midrst_flag_z", {31'd0, flag_z}, 32'd0);
        rst = 1'b0;
        q_exp.delete();
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 32'd0);
        @(posedge clk); #1;

        issue(vecs[13]);
        wait_done(2, 1, "illegal_after_reset");

        chk("scoreboard_drained", q_exp.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
